// File: rtl/mips_control_muldiv_sequencer.sv
// Iterative HI/LO multiply/divide sequencer: radix-2 shift-add multiply, restoring divide.
// Optional feature macro: MIPS_CONTROL_MULDIV_EARLY_OUT_EN (multiply exits once remaining multiplier bits are zero).
module mips_control_muldiv_sequencer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] dataA,
    input  logic [DATA_WIDTH-1:0] dataB,
    input  logic                  flush,
    input  logic                  writeHi,
    input  logic                  writeLo,
    input  logic [DATA_WIDTH-1:0] writeData,
    input  logic                  readHi,
    input  logic                  readLo,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo,
    output logic                  busy,
    output logic                  done,
    output logic                  stall
);

    localparam int DW = DATA_WIDTH;
    localparam int CW = $clog2(DW);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIXUP} state_t;

    state_t          state, state_next;
    logic [CW-1:0]   count;
    logic [2*DW-1:0] acc;      // product, or remainder:quotient
    logic [DW-1:0]   opb;      // shifting multiplier, or fixed divisor
`ifdef MIPS_CONTROL_MULDIV_EARLY_OUT_EN
    logic [2*DW-1:0] mcand;
`else
    logic [DW-1:0]   mcand;
`endif
    logic            is_div, neg_res, neg_rem, div_zero;

    logic            load, iter_last, finish;
    logic            signed_op, neg_a, neg_b;
    logic [DW-1:0]   abs_a, abs_b;
    logic [2*DW-1:0] mul_next, div_next, fix_src, prod_fix;
    logic [DW:0]     div_trial;
    logic [DW-1:0]   quot, rem, hi_fix, lo_fix;

    assign signed_op = ~op[0];
    assign neg_a     = signed_op & dataA[DW-1];
    assign neg_b     = signed_op & dataB[DW-1];
    assign abs_a     = neg_a ? -dataA : dataA;
    assign abs_b     = neg_b ? -dataB : dataB;

`ifdef MIPS_CONTROL_MULDIV_EARLY_OUT_EN
    // Left-shifting multiplicand keeps the partial product aligned when the loop exits early.
    assign mul_next = acc + (opb[0] ? mcand : '0);
    assign fix_src  = (state == S_MUL) ? mul_next : acc;
`else
    logic [DW:0] mul_sum;
    assign mul_sum  = {1'b0, acc[2*DW-1:DW]} + {1'b0, (opb[0] ? mcand : '0)};
    assign mul_next = {mul_sum, acc[DW-1:1]};
    assign fix_src  = acc;
`endif

    // Trial subtract uses the bit shifted out of the remainder, so divisors above 2^(DW-1) work.
    assign div_trial = acc[2*DW-1:DW-1] - {1'b0, opb};
    assign div_next  = div_trial[DW] ? {acc[2*DW-2:0], 1'b0}
                                     : {div_trial[DW-1:0], acc[DW-2:0], 1'b1};

    // Signed overflow (most negative / -1) needs no special case: -0x80..0 wraps to itself.
    // Divide by zero leaves remainder = |dataA|, so the remainder sign fixup restores dataA.
    assign prod_fix = neg_res ? -fix_src : fix_src;
    assign quot     = acc[DW-1:0];
    assign rem      = acc[2*DW-1:DW];
    assign lo_fix   = !is_div ? prod_fix[DW-1:0]
                    : div_zero ? '1
                    : (neg_res ? -quot : quot);
    assign hi_fix   = !is_div ? prod_fix[2*DW-1:DW] : (neg_rem ? -rem : rem);

    assign iter_last = (count == CW'(DW - 1));
    assign busy      = (state != S_IDLE);
    assign stall     = busy & (start | readHi | readLo | writeHi | writeLo);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        finish     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = op[1] ? S_DIV : S_MUL;
                end
            end
            S_MUL: begin
`ifdef MIPS_CONTROL_MULDIV_EARLY_OUT_EN
                if (opb[DW-1:1] == '0) begin
                    finish     = 1'b1;
                    state_next = S_IDLE;
                end
`else
                if (iter_last) state_next = S_FIXUP;
`endif
            end
            S_DIV: begin
                if (iter_last) state_next = S_FIXUP;
            end
            S_FIXUP: begin
                finish     = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        if (flush) begin
            state_next = S_IDLE;
            load       = 1'b0;
            finish     = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state <= S_IDLE;
            count <= '0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_next;
            done  <= finish;
            if (load)
                count <= '0;
            else if (state == S_MUL || state == S_DIV)
                count <= count + 1'b1;
            if (finish) begin
                hi <= hi_fix;
                lo <= lo_fix;
            end else if (state == S_IDLE && !flush) begin
                if (writeHi) hi <= writeData;
                if (writeLo) lo <= writeData;
            end
        end
    end

    // NOTE: datapath registers carry no reset; they are always loaded before being read.
    always_ff @(posedge clock) begin
        if (load) begin
            acc      <= op[1] ? {{DW{1'b0}}, abs_a} : '0;
`ifdef MIPS_CONTROL_MULDIV_EARLY_OUT_EN
            mcand    <= {{DW{1'b0}}, abs_a};
`else
            mcand    <= abs_a;
`endif
            opb      <= abs_b;
            is_div   <= op[1];
            neg_res  <= neg_a ^ neg_b;
            neg_rem  <= neg_a;
            div_zero <= op[1] & (dataB == '0);
        end else if (state == S_MUL) begin
            acc <= mul_next;
            opb <= opb >> 1;
`ifdef MIPS_CONTROL_MULDIV_EARLY_OUT_EN
            mcand <= mcand << 1;
`endif
        end else if (state == S_DIV) begin
            acc <= div_next;
        end
    end

endmodule

// File: tb/tb_mips_control_muldiv_sequencer.sv
// Self-checking bench for mips_control_muldiv_sequencer: reference model feeds a HI/LO scoreboard
// checked on every done pulse; latency, stall, flush and reset behaviour checked directly.
module tb_mips_control_muldiv_sequencer;

    logic        clock = 1'b0;
    logic        resetN;
    logic        start, flush, writeHi, writeLo, readHi, readLo;
    logic [1:0]  op;
    logic [31:0] dataA, dataB, writeData;
    logic [31:0] hi, lo;
    logic        busy, done, stall;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] sb[$];

    localparam logic [1:0] OP_MULT = 2'd0, OP_MULTU = 2'd1, OP_DIV = 2'd2, OP_DIVU = 2'd3;
`ifdef MIPS_CONTROL_MULDIV_EARLY_OUT_EN
    localparam logic [31:0] LONG_B = 32'h8000_0005;
`else
    localparam logic [31:0] LONG_B = 32'd5;
`endif

    mips_control_muldiv_sequencer #(.DATA_WIDTH(32)) dut (
        .clock(clock), .resetN(resetN), .start(start), .op(op),
        .dataA(dataA), .dataB(dataB), .flush(flush),
        .writeHi(writeHi), .writeLo(writeLo), .writeData(writeData),
        .readHi(readHi), .readLo(readLo),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Returns {hi, lo}.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb_, q, r;
        logic [63:0] p;
        sa  = longint'(signed'(a));
        sb_ = longint'(signed'(b));
        case (o)
            OP_MULT:  begin p = sa * sb_; return p; end
            OP_MULTU: return {32'd0, a} * {32'd0, b};
            OP_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = sa / sb_;
                r = sa % sb_;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Number of falling edges after the sampling edge E0 until done is seen.
    function automatic int exp_lat(input logic [1:0] o, input logic [31:0] b);
`ifdef MIPS_CONTROL_MULDIV_EARLY_OUT_EN
        logic [31:0] mb;
        int iters;
        if (o[1]) return 34;
        mb = (!o[0] && b[31]) ? -b : b;
        iters = 1;
        for (int i = 1; i < 32; i++) if (mb[i]) iters = i + 1;
        return iters + 1;
`else
        return (o == 2'd0 || o != 2'd0) ? 34 : 0;
`endif
    endfunction

    // Scoreboard: every done pulse must match the oldest expected result.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clock);
            if (resetN && done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("hi", {32'd0, hi}, {32'd0, e[63:32]});
                    check("lo", {32'd0, lo}, {32'd0, e[31:0]});
                    check("busy_in_done", {63'd0, busy}, 64'd0);
                end
            end
        end
    end

    task automatic wait_done(output int n);
        n = 0;
        while (n < 80) begin
            @(negedge clock);
            n++;
            if (done) break;
        end
        if (!done) check("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int n;
        op = o; dataA = a; dataB = b; start = 1'b1;
        sb.push_back(model(o, a, b));
        @(posedge clock); #1;
        start = 1'b0;
        check("busy_after_start", {63'd0, busy}, 64'd1);
        wait_done(n);
        check("latency", 64'(n), 64'(exp_lat(o, b)));
        @(posedge clock); #1;
    endtask

    task automatic mt(input logic is_hi, input logic [31:0] d);
        writeHi = is_hi; writeLo = !is_hi; writeData = d;
        @(posedge clock); #1;
        writeHi = 1'b0; writeLo = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        resetN = 1'b0; start = 1'b0; flush = 1'b0; op = 2'd0;
        dataA = '0; dataB = '0; writeHi = 1'b0; writeLo = 1'b0; writeData = '0;
        readHi = 1'b1; readLo = 1'b0;
        #12;
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_stall", {63'd0, stall}, 64'd0);
        readHi = 1'b0;
        @(negedge clock); resetN = 1'b1;
        @(posedge clock); #1;

        mt(1'b1, 32'h11);
        mt(1'b0, 32'h22);
        check("mthi", {32'd0, hi}, 64'h11);
        check("mtlo", {32'd0, lo}, 64'h22);

        run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3);

        // Reset in the middle of a multiply.
        op = OP_MULTU; dataA = 32'd3; dataB = LONG_B; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (9) @(posedge clock);
        @(posedge clock); #2;
        resetN = 1'b0;
        #1;
        check("midrst_hi", {32'd0, hi}, 64'd0);
        check("midrst_lo", {32'd0, lo}, 64'd0);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_done", {63'd0, done}, 64'd0);
        @(negedge clock); resetN = 1'b1;
        repeat (40) @(posedge clock);
        #1;
        check("midrst_idle_hi", {32'd0, hi}, 64'd0);

        run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2);
        run_op(OP_DIVU,  32'd7,         32'd0);
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'd0);
        run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
        run_op(OP_DIVU,  32'hFFFF_FFFF, 32'h8000_0001);
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(OP_MULT,  32'h8000_0000, 32'h8000_0000);
        run_op(OP_MULTU, 32'd9,         32'd1);
        run_op(OP_MULT,  32'h1234_5678, 32'd0);
        for (int i = 0; i < 6; i++)
            run_op(2'($urandom_range(0, 3)), $urandom, $urandom_range(0, 1) != 0 ? $urandom : $urandom_range(1, 300));

        // MFHI plus a second start while busy: held until the done cycle, then accepted.
        op = OP_MULTU; dataA = 32'd3; dataB = LONG_B; start = 1'b1;
        sb.push_back(model(OP_MULTU, 32'd3, LONG_B));
        @(posedge clock); #1;
        start = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        op = OP_MULTU; dataA = 32'd7; dataB = 32'd6; start = 1'b1; readHi = 1'b1;
        n = 0;
        while (n < 80) begin
            @(negedge clock);
            n++;
            if (done) break;
            check("stall_busy", {63'd0, stall}, 64'd1);
        end
        check("stall_done_seen", {63'd0, done}, 64'd1);
        check("stall_in_done", {63'd0, stall}, 64'd0);
        check("mfhi_in_done", {hi, lo}, model(OP_MULTU, 32'd3, LONG_B));
        sb.push_back(model(OP_MULTU, 32'd7, 32'd6));
        @(posedge clock); #1;
        start = 1'b0; readHi = 1'b0;
        check("b2b_busy", {63'd0, busy}, 64'd1);
        wait_done(n);
        check("b2b_latency", 64'(n), 64'(exp_lat(OP_MULTU, 32'd6)));
        @(posedge clock); #1;

        // Flush mid-divide keeps MTHI/MTLO values and produces no done.
        mt(1'b1, 32'h11);
        mt(1'b0, 32'h22);
        op = OP_DIVU; dataA = 32'd100; dataB = 32'd7; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (20) @(posedge clock);
        #1 flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        check("flush_idle", {63'd0, busy}, 64'd0);
        repeat (40) @(posedge clock);
        #1;
        check("flush_hi", {32'd0, hi}, 64'h11);
        check("flush_lo", {32'd0, lo}, 64'h22);

        // Flush beats start in IDLE.
        op = OP_MULTU; dataA = 32'd2; dataB = 32'd2; start = 1'b1; flush = 1'b1;
        @(posedge clock); #1;
        start = 1'b0; flush = 1'b0;
        check("flush_start_busy", {63'd0, busy}, 64'd0);
        repeat (40) @(posedge clock);
        #1;

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
